exdecompress_v2: RTL and testbench

Parametrised decompressor for the exbus command stream. It expands 35-bit compressed words from the link decoder into full 35-bit bus commands for the bus master. Compared with the first-generation decompressor it adds:
- a configurable history-table depth;
- fill tracking, so a lookup into never-written history returns an error word instead of stale RAM contents;
- an in-band table-reset command.

---
 rtl/exdecompress_v2.sv | 174 +++++++++++++++++
 tb/tb_exdecompress_v2.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exdecompress_v2.sv
// rtl/exdecompress_v2.sv - exbus compressed-word expander with fill-tracked history table
// Ports:
//   i_clk, i_reset          system clock, asynchronous active-high reset
//   i_stb, o_busy, i_word   compressed input stream, i_word[34:33] is the word type
//   o_stb, i_busy, o_word   expanded bus-command output stream
//   o_active                a word is in flight in stage R or stage Q
module exdecompress_v2 #(
    parameter int LGTABLE      = 10,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    output logic        o_busy,
    input  logic [34:0] i_word,
    output logic        o_stb,
    input  logic        i_busy,
    output logic [34:0] o_word,
    output logic        o_active
);
    localparam int DW = LGTABLE + 1;
    localparam logic [DW-1:0] FULL = DW'(1) << LGTABLE;
    localparam logic [34:0] ERR_WORD = {2'b11, 5'b11110, 28'h0};

    // Stage R (decode)
    logic          r_stb, r_write, r_lookup, r_treset;
    logic [34:0]   r_word;
    logic [DW-1:0] r_dist;
    // Stage Q (table access)
    logic          q_stb, q_lookup;
    logic [34:0]   q_word, q_out;
    logic [31:0]   rd_data;
    // Table state
    logic [LGTABLE-1:0] wr_ptr, rd_idx;
    logic [DW-1:0]      fill;
    logic [31:0]        hist [0:(1<<LGTABLE)-1];

    logic q_busy, r_busy, r_go;
    logic [34:0]   dec_word;
    logic          dec_write, dec_lookup, dec_treset;
    logic [DW-1:0] dec_dist;
    logic [11:0]   dec_count;

    assign q_busy   = o_stb && i_busy;
    assign r_busy   = q_stb && q_busy;
    assign o_busy   = r_stb && r_busy;
    assign r_go     = r_stb && !r_busy;
    assign o_active = r_stb || q_stb;

    always_comb begin
        dec_word   = '0;
        dec_write  = 1'b0;
        dec_lookup = 1'b0;
        dec_treset = 1'b0;
        dec_dist   = '0;
        dec_count  = '0;
        case (i_word[34:33])
            2'b00: begin
                casez (i_word[32:29])
                    4'b0???: dec_word = {3'b000, i_word[31:2], 1'b0, i_word[0]};
                    4'b10??: dec_word = {3'b001, {29{i_word[30]}}, i_word[29], 1'b0, i_word[28]};
                    4'b110?: dec_word = {2'b00, i_word[29], {24{i_word[28]}}, i_word[27:22], 1'b0, i_word[21]};
                    default: dec_word = {2'b00, i_word[29], {17{i_word[28]}}, i_word[27:15], 1'b0, i_word[14]};
                endcase
            end
            2'b01: begin
                casez (i_word[32:30])
                    3'b0??: begin
                        dec_word  = {3'b010, i_word[31:0]};
                        dec_write = 1'b1;
                    end
                    3'b110: dec_word = {3'b010, {24{i_word[29]}}, i_word[28:21]};
                    3'b111: begin
                        dec_word  = {3'b010, {17{i_word[29]}}, i_word[28:14]};
                        dec_write = 1'b1;
                    end
                    3'b100: begin
                        dec_lookup = 1'b1;
                        dec_dist   = DW'(i_word[29:28]) + DW'(1);
                    end
                    default: begin
                        dec_lookup = 1'b1;
                        dec_dist   = DW'(i_word[29:21]) + DW'(1);
                    end
                endcase
            end
            2'b10: begin
                dec_count = i_word[32] ? (12'(i_word[31:21]) + 12'd17) : (12'(i_word[31:28]) + 12'd1);
                dec_word  = {3'b100, 20'h0, dec_count};
            end
            default: begin
                if (i_word[32:28] == 5'b11111)
                    dec_treset = 1'b1;
                else
                    dec_word = {2'b11, i_word[32:28], 28'h0};
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stb    <= 1'b0;
            r_write  <= 1'b0;
            r_lookup <= 1'b0;
            r_treset <= 1'b0;
            r_word   <= '0;
            r_dist   <= '0;
        end else if (!o_busy) begin
            r_stb    <= i_stb;
            r_write  <= i_stb && dec_write;
            r_lookup <= i_stb && dec_lookup;
            r_treset <= i_stb && dec_treset;
            r_word   <= (OPT_LOWPOWER && !i_stb) ? '0 : dec_word;
            r_dist   <= (OPT_LOWPOWER && !i_stb) ? '0 : dec_dist;
        end
    end

    // wr_ptr/fill move as the write leaves R, so a lookup directly behind it
    // already indexes relative to the new entry.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            q_stb    <= 1'b0;
            q_lookup <= 1'b0;
            q_word   <= '0;
            wr_ptr   <= '0;
            fill     <= '0;
        end else begin
            if (!r_busy) begin
                // A table reset is consumed here and never reaches stage O.
                q_stb    <= r_stb && !r_treset;
                q_lookup <= r_stb && r_lookup && !(r_dist > fill);
                if (r_stb && r_lookup && (r_dist > fill))
                    q_word <= ERR_WORD;
                else if (OPT_LOWPOWER && !r_stb)
                    q_word <= '0;
                else
                    q_word <= r_word;
            end
            if (r_go) begin
                if (r_treset) begin
                    wr_ptr <= '0;
                    fill   <= '0;
                end else if (r_write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill != FULL)
                        fill <= fill + DW'(1);
                end
            end
        end
    end

    assign rd_idx = wr_ptr - r_dist[LGTABLE-1:0];

    // History RAM is deliberately unreset; fill=0 hides stale entries.
    always_ff @(posedge i_clk) begin
        if (r_go && r_write)
            hist[wr_ptr] <= r_word[31:0];
        if (r_go && r_lookup)
            rd_data <= hist[rd_idx];
    end

    assign q_out = q_lookup ? {3'b010, rd_data} : q_word;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stb <= 1'b0;
            if (OPT_LOWPOWER)
                o_word <= '0;
        end else if (!q_busy) begin
            o_stb  <= q_stb;
            o_word <= (OPT_LOWPOWER && !q_stb) ? '0 : q_out;
        end
    end
endmodule

// File: tb/tb_exdecompress_v2.sv
// tb/tb_exdecompress_v2.sv - self-checking bench for exdecompress_v2 (LGTABLE=9)
module tb_exdecompress_v2;
    localparam int TD = 512;
    localparam logic [34:0] ERR = {2'b11, 5'b11110, 28'h0};

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stb, i_busy;
    logic [34:0] i_word;
    logic        o_busy, o_stb, o_active;
    logic [34:0] o_word;

    int          n_cmp, n_fail;
    logic [34:0] exp_q[$];
    logic [34:0] got_q[$];
    logic [31:0] mtab [TD];
    int          mwp, mfill;
    bit          hold_v, rnd_busy;
    logic [34:0] hold_w;

    exdecompress_v2 #(.LGTABLE(9), .OPT_LOWPOWER(1'b0)) dut (
        .i_clk(clk), .i_reset(rst), .i_stb(i_stb), .o_busy(o_busy), .i_word(i_word),
        .o_stb(o_stb), .i_busy(i_busy), .o_word(o_word), .o_active(o_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        logic signed [31:0] t;
        t = $signed(v << (32 - n));
        return 32'(t >>> (32 - n));
    endfunction

    function automatic logic [31:0] vval(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Sequential reference: each accepted word is processed fully in order.
    task automatic model_accept(input logic [34:0] w);
        logic [34:0] e;
        logic [31:0] lo;
        int d, cnt;
        bit emit;
        emit = 1;
        d = 0;
        e = '0;
        case (w[34:33])
            2'b00: begin
                if (!w[32])      e = {3'b000, w[31:0] & ~32'h2};
                else if (!w[31]) e = {3'b001, (sx(32'(w[30:29]), 2) << 2) | 32'(w[28])};
                else if (!w[30]) e = {2'b00, w[29], (sx(32'(w[28:22]), 7) << 2) | 32'(w[21])};
                else             e = {2'b00, w[29], (sx(32'(w[28:15]), 14) << 2) | 32'(w[14])};
            end
            2'b01: begin
                if (!w[32] || w[31:30] == 2'b11) begin
                    lo = !w[32] ? w[31:0] : sx(32'(w[29:14]), 16);
                    e = {3'b010, lo};
                    mtab[mwp] = lo;
                    mwp = (mwp + 1) % TD;
                    if (mfill < TD) mfill++;
                end else if (w[31:30] == 2'b10) begin
                    e = {3'b010, sx(32'(w[29:21]), 9)};
                end else begin
                    d = (w[31:30] == 2'b00) ? int'(w[29:28]) + 1 : int'(w[29:21]) + 1;
                    e = (d > mfill) ? ERR : {3'b010, mtab[(mwp - d + TD) % TD]};
                end
            end
            2'b10: begin
                cnt = w[32] ? 17 + int'(w[31:21]) : 1 + int'(w[31:28]);
                e = {3'b100, 20'h0, 12'(cnt)};
            end
            default: begin
                if (w[32:28] == 5'b11111) begin
                    mwp = 0;
                    mfill = 0;
                    emit = 0;
                end else e = {2'b11, w[32:28], 28'h0};
            end
        endcase
        if (emit) exp_q.push_back(e);
    endtask

    task automatic mon_step();
        if (rst) begin
            exp_q.delete();
            mwp = 0;
            mfill = 0;
            hold_v = 0;
            return;
        end
        if (hold_v) begin
            chk("hold_stb", 35'(o_stb), 35'd1);
            chk("hold_word", o_word, hold_w);
        end
        hold_v = o_stb && i_busy;
        hold_w = o_word;
        if (o_stb && !i_busy) begin
            got_q.push_back(o_word);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL extra_output: got %h required no output", o_word);
            end else chk("model_out", o_word, exp_q.pop_front());
        end
        if (i_stb && !o_busy) model_accept(i_word);
    endtask

    task automatic send(input logic [34:0] w);
        int t;
        bit acc;
        t = 0;
        i_stb = 1;
        i_word = w;
        while (1) begin
            @(negedge clk);
            acc = !o_busy;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 300) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: o_busy 1 required 0 within 300 cycles");
                break;
            end
        end
        i_stb = 0;
    endtask

    task automatic idle(input int n);
        i_stb = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        got_q.delete();
    endtask

    function automatic logic [34:0] rand_word();
        logic [34:0] w;
        int k;
        w[31:0] = $urandom();
        w[34:32] = 3'($urandom_range(0, 7));
        k = $urandom_range(0, 39);
        if (k < 6) w[34:33] = 2'b00;
        else if (k < 18) w[34:32] = 3'b010;
        else if (k < 21) w[34:31] = 4'b0111;
        else if (k < 28) w[34:30] = 5'b01100;
        else if (k < 32) begin
            w[34:30] = 5'b01101;
            if ($urandom_range(0, 1) == 1) w[29:21] = 9'($urandom_range(0, 31));
        end else if (k < 36) w[34:33] = 2'b10;
        else if (k < 39) begin
            w[34:33] = 2'b11;
            if (w[32:28] == 5'b11111) w[28] = 1'b0;
        end else w[34:28] = 7'b1111111;
        return w;
    endfunction

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1;
        i_stb = 0;
        i_busy = 0;
        i_word = '0;
        rnd_busy = 0;
        hold_v = 0;
        mwp = 0;
        mfill = 0;
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk);
                #1;
                if (rnd_busy) i_busy = ($urandom_range(0, 3) == 0);
            end
        join_none

        @(posedge clk);
        #1;
        chk("reset_o_stb", 35'(o_stb), 35'd0);
        chk("reset_o_busy", 35'(o_busy), 35'd0);
        chk("reset_o_active", 35'(o_active), 35'd0);
        @(posedge clk);
        #1;
        rst = 0;

        // Absolute address and 3-cycle latency
        send({2'b00, 1'b0, 32'h12345679});
        chk("lat1_active", 35'(o_active), 35'd1);
        chk("lat1_stb", 35'(o_stb), 35'd0);
        idle(1);
        chk("lat2_stb", 35'(o_stb), 35'd0);
        idle(1);
        chk("lat3_stb", 35'(o_stb), 35'd1);
        chk("lat3_word", o_word, {3'b000, 30'h048D159E, 1'b0, 1'b1});
        idle(4);
        got_q.delete();

        // Assorted encodings with hand-computed results
        send({2'b00, 4'b1010, 29'h0});
        send({2'b10, 1'b1, 11'd2047, 21'h0});
        send({2'b11, 5'b00101, 28'h0});
        send({2'b01, 3'b110, 9'h180, 21'h0});
        idle(6);
        chk("misc_n", 35'(got_q.size()), 35'd4);
        chk("misc_addr", got_q[0], {3'b001, 32'hFFFFFFF8});
        chk("misc_read", got_q[1], {3'b100, 20'h0, 12'h810});
        chk("misc_special", got_q[2], {2'b11, 5'b00101, 28'h0});
        chk("misc_wr110", got_q[3], {3'b010, 32'hFFFFFF80});

        // Back-to-back write then lookup d=1
        do_reset();
        send({2'b01, 1'b0, 32'hDEADBEEF});
        send({2'b01, 3'b100, 2'b00, 28'h0});
        idle(6);
        chk("b2b_n", 35'(got_q.size()), 35'd2);
        chk("b2b_w", got_q[0], {3'b010, 32'hDEADBEEF});
        chk("b2b_l", got_q[1], {3'b010, 32'hDEADBEEF});

        // Lookup beyond fill
        do_reset();
        send({2'b01, 1'b0, 32'h0BADF00D});
        send({2'b01, 3'b100, 2'b01, 28'h0});
        idle(6);
        chk("fill_w", got_q[0], {3'b010, 32'h0BADF00D});
        chk("fill_err", got_q[1], ERR);

        // In-band table reset
        do_reset();
        send({2'b01, 1'b0, 32'h13579BDF});
        send({2'b11, 5'b11111, 28'h0});
        send({2'b01, 3'b100, 2'b00, 28'h0});
        idle(6);
        chk("treset_n", 35'(got_q.size()), 35'd2);
        chk("treset_a", got_q[0], {3'b010, 32'h13579BDF});
        chk("treset_err", got_q[1], ERR);

        // Wrap and fill saturation
        do_reset();
        for (int i = 0; i <= 512; i++) send({2'b01, 1'b0, vval(i)});
        send({2'b01, 3'b101, 9'd511, 21'h0});
        send({2'b01, 3'b100, 2'b00, 28'h0});
        idle(6);
        chk("wrap_n", 35'(got_q.size()), 35'd515);
        chk("wrap_d512", got_q[513], {3'b010, vval(1)});
        chk("wrap_d1", got_q[514], {3'b010, vval(512)});

        // Backpressure: 10-cycle stall over 5 words
        do_reset();
        i_busy = 1;
        fork
            begin
                repeat (10) @(posedge clk);
                #1;
                i_busy = 0;
            end
        join_none
        for (int k = 0; k < 3; k++) send({2'b10, 1'b0, 4'(k), 28'h0});
        chk("bp_o_busy", 35'(o_busy), 35'd1);
        chk("bp_active", 35'(o_active), 35'd1);
        for (int k = 3; k < 5; k++) send({2'b10, 1'b0, 4'(k), 28'h0});
        idle(8);
        chk("bp_n", 35'(got_q.size()), 35'd5);
        for (int k = 0; k < 5; k++) chk("bp_order", got_q[k], {3'b100, 20'h0, 12'(k + 1)});

        // Asynchronous reset during a stall
        got_q.delete();
        i_busy = 1;
        send({2'b10, 1'b0, 4'd7, 28'h0});
        send({2'b10, 1'b0, 4'd8, 28'h0});
        idle(2);
        chk("rs_pre_stb", 35'(o_stb), 35'd1);
        rst = 1;
        #1;
        chk("rs_o_stb", 35'(o_stb), 35'd0);
        chk("rs_o_busy", 35'(o_busy), 35'd0);
        chk("rs_o_active", 35'(o_active), 35'd0);
        @(posedge clk);
        #1;
        rst = 0;
        i_busy = 0;
        idle(6);
        chk("rs_dropped", 35'(got_q.size()), 35'd0);

        // Randomized traffic against the reference model
        rnd_busy = 1;
        for (int n = 0; n < 1500; n++) begin
            idle($urandom_range(0, 2));
            send(rand_word());
        end
        rnd_busy = 0;
        @(posedge clk);
        #1;
        i_busy = 0;
        idle(12);
        chk("rand_drained", 35'(exp_q.size()), 35'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
